// File: rtl/fetch.sv
// Instruction fetch stage: issues one memory request at a time, buffers the returned
// word and hands it to decode, honouring branch redirects (with delay slot) and exception flushes.
module fetch (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        flush_f,
  input  logic [31:0] exc_pc,
  input  logic        stall_f,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_pcplus4,
  output logic [31:0] out_instr,
  output logic        out_exc_adel
);

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e      state_q,    state_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] pend_q,     pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        discard_q,  discard_d;
  logic [31:0] buf_q,      buf_d;
  logic        adel_q,     adel_d;

  logic        pc_aligned;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      discard_q  <= 1'b0;
      buf_q      <= '0;
      adel_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      discard_q  <= discard_d;
      buf_q      <= buf_d;
      adel_q     <= adel_d;
    end
  end

  assign pc_aligned = (pc_q[1:0] == 2'b00);
  assign pc_plus4   = pc_q + 32'd4;

  // A redirect arriving in the consuming cycle bypasses the pending register.
  assign next_pc = redirect_valid ? redirect_pc :
                   pend_vld_q     ? pend_q      : pc_plus4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    discard_d  = discard_q;
    buf_d      = buf_q;
    adel_d     = adel_q;
    ireq_valid = (state_q == S_REQ) && pc_aligned;

    if (flush_f) begin
      pc_d       = exc_pc;
      pend_vld_d = 1'b0;
      case (state_q)
        S_REQ: begin
          if (ireq_valid && ireq_ready) begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          // A response in the flush cycle is the stale one: nothing is left outstanding.
          if (iresp_valid) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      if (redirect_valid) begin
        pend_d     = redirect_pc;
        pend_vld_d = 1'b1;
      end
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (!pc_aligned) begin
            buf_d   = '0;
            adel_d  = 1'b1;
            state_d = S_DONE;
          end else if (ireq_ready) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (iresp_valid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else begin
              buf_d   = iresp_data;
              adel_d  = 1'b0;
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!stall_f) begin
            pc_d       = next_pc;
            pend_vld_d = 1'b0;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ireq_addr    = pc_q;
  assign out_valid    = (state_q == S_DONE);
  assign out_pc       = pc_q;
  assign out_pcplus4  = pc_plus4;
  assign out_instr    = buf_q;
  assign out_exc_adel = adel_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed cycle table, reset/wrap sequences, then random traffic
// checked against an instruction-stream model of the program counter.
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_f;
  logic [31:0] exc_pc;
  logic        stall_f;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_pcplus4;
  logic [31:0] out_instr;
  logic        out_exc_adel;

  fetch dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_f(flush_f), .exc_pc(exc_pc), .stall_f(stall_f),
    .out_valid(out_valid), .out_pc(out_pc), .out_pcplus4(out_pcplus4),
    .out_instr(out_instr), .out_exc_adel(out_exc_adel)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        rdir;
    logic [31:0] rpc;
    logic        fl;
    logic [31:0] ep;
    logic        st;
    logic        eiv;
    logic [31:0] ea;
    logic        eov;
    logic [31:0] epc;
    logic [31:0] ei;
    logic        ead;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic rdir, input logic [31:0] rpc,
                              input logic fl, input logic [31:0] ep, input logic st,
                              input logic eiv, input logic [31:0] ea,
                              input logic eov, input logic [31:0] epc,
                              input logic [31:0] ei, input logic ead);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rd = rd; v.rdir = rdir; v.rpc = rpc;
    v.fl = fl; v.ep = ep; v.st = st; v.eiv = eiv; v.ea = ea;
    v.eov = eov; v.epc = epc; v.ei = ei; v.ead = ead;
    return v;
  endfunction

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic rdir, input logic [31:0] rpc,
                       input logic fl, input logic [31:0] ep, input logic st);
    ireq_ready = rdy; iresp_valid = rv; iresp_data = rd;
    redirect_valid = rdir; redirect_pc = rpc;
    flush_f = fl; exc_pc = ep; stall_f = st;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ireq_valid"}, {31'b0, ireq_valid}, 32'h0);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'h0);
    chk({tag, "_out_instr"}, out_instr, 32'h0);
    chk({tag, "_out_adel"}, {31'b0, out_exc_adel}, 32'h0);
    chk({tag, "_out_pc"}, out_pc, 32'hBFC0_0000);
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  localparam logic [31:0] Z = 32'h0;

  task automatic build_table();
    //        rdy  rv   rd            rdir rpc           fl   ep            st | eiv ea            eov pc            instr         adel
    tbl.push_back(mk(0, 0, Z,            0, Z,            0, Z,            0,   0, Z,            0, Z,            Z,            0));
    tbl.push_back(mk(1, 0, Z,            0, Z,            0, Z,            0,   1, 32'hBFC00000, 0, Z,            Z,            0));
    tbl.push_back(mk(0, 1, 32'h24020001, 0, Z,            0, Z,            0,   0, Z,            0, Z,            Z,            0));
    tbl.push_back(mk(0, 0, Z,            0, Z,            0, Z,            0,   0, Z,            1, 32'hBFC00000, 32'h24020001, 0));
    tbl.push_back(mk(1, 0, Z,            0, Z,            0, Z,            0,   1, 32'hBFC00004, 0, Z,            Z,            0));
    tbl.push_back(mk(0, 1, 32'h3C011234, 0, Z,            0, Z,            0,   0, Z,            0, Z,            Z,            0));
    tbl.push_back(mk(0, 0, Z,            0, Z,            0, Z,            0,   0, Z,            1, 32'hBFC00004, 32'h3C011234, 0));
    tbl.push_back(mk(1, 0, Z,            0, Z,            0, Z,            0,   1, 32'hBFC00008, 0, Z,            Z,            0));
    tbl.push_back(mk(0, 0, Z,            0, Z,            1, 32'hBFC00380, 0,   0, Z,            0, Z,            Z,            0));
    tbl.push_back(mk(0, 1, 32'hDEADBEEF, 0, Z,            0, Z,            0,   0, Z,            0, Z,            Z,            0));
    tbl.push_back(mk(1, 0, Z,            1, 32'h80001000, 0, Z,            0,   1, 32'hBFC00380, 0, Z,            Z,            0));
    tbl.push_back(mk(0, 1, 32'h40806000, 0, Z,            0, Z,            0,   0, Z,            0, Z,            Z,            0));
    tbl.push_back(mk(0, 0, Z,            0, Z,            0, Z,            0,   0, Z,            1, 32'hBFC00380, 32'h40806000, 0));
    tbl.push_back(mk(1, 0, Z,            0, Z,            0, Z,            0,   1, 32'h80001000, 0, Z,            Z,            0));
    tbl.push_back(mk(0, 1, 32'h8C220000, 0, Z,            0, Z,            0,   0, Z,            0, Z,            Z,            0));
    tbl.push_back(mk(0, 0, Z,            1, 32'h80000002, 0, Z,            0,   0, Z,            1, 32'h80001000, 32'h8C220000, 0));
    tbl.push_back(mk(1, 0, Z,            0, Z,            0, Z,            0,   0, Z,            0, Z,            Z,            0));
    tbl.push_back(mk(0, 0, Z,            1, 32'h80002000, 0, Z,            0,   0, Z,            1, 32'h80000002, Z,            1));
    tbl.push_back(mk(0, 0, Z,            0, Z,            0, Z,            0,   1, 32'h80002000, 0, Z,            Z,            0));
    tbl.push_back(mk(0, 0, Z,            0, Z,            0, Z,            0,   1, 32'h80002000, 0, Z,            Z,            0));
    tbl.push_back(mk(1, 0, Z,            0, Z,            0, Z,            0,   1, 32'h80002000, 0, Z,            Z,            0));
    tbl.push_back(mk(0, 1, 32'h12345678, 0, Z,            0, Z,            0,   0, Z,            0, Z,            Z,            0));
    tbl.push_back(mk(0, 0, Z,            0, Z,            0, Z,            1,   0, Z,            1, 32'h80002000, 32'h12345678, 0));
    tbl.push_back(mk(0, 0, Z,            0, Z,            0, Z,            1,   0, Z,            1, 32'h80002000, 32'h12345678, 0));
    tbl.push_back(mk(0, 0, Z,            0, Z,            0, Z,            1,   0, Z,            1, 32'h80002000, 32'h12345678, 0));
    tbl.push_back(mk(0, 0, Z,            0, Z,            0, Z,            0,   0, Z,            1, 32'h80002000, 32'h12345678, 0));
    tbl.push_back(mk(1, 0, Z,            0, Z,            0, Z,            0,   1, 32'h80002004, 0, Z,            Z,            0));
    tbl.push_back(mk(0, 1, 32'hAAAA5555, 0, Z,            0, Z,            0,   0, Z,            0, Z,            Z,            0));
    tbl.push_back(mk(0, 0, Z,            0, Z,            1, 32'hBFC00380, 0,   0, Z,            1, 32'h80002004, 32'hAAAA5555, 0));
    tbl.push_back(mk(0, 0, Z,            1, 32'h80003000, 1, 32'hBFC00200, 0,   1, 32'hBFC00380, 0, Z,            Z,            0));
    tbl.push_back(mk(1, 0, Z,            0, Z,            0, Z,            0,   1, 32'hBFC00200, 0, Z,            Z,            0));
    tbl.push_back(mk(0, 1, 32'h11112222, 0, Z,            0, Z,            0,   0, Z,            0, Z,            Z,            0));
    tbl.push_back(mk(0, 0, Z,            0, Z,            0, Z,            0,   0, Z,            1, 32'hBFC00200, 32'h11112222, 0));
    tbl.push_back(mk(1, 0, Z,            0, Z,            1, 32'hBFC00380, 0,   1, 32'hBFC00204, 0, Z,            Z,            0));
    tbl.push_back(mk(0, 1, 32'h33334444, 0, Z,            0, Z,            0,   0, Z,            0, Z,            Z,            0));
    tbl.push_back(mk(0, 0, Z,            0, Z,            0, Z,            0,   1, 32'hBFC00380, 0, Z,            Z,            0));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
  endtask

  // Stream model state for the random phase.
  logic [31:0] m_pc, m_pend, mem_addr;
  logic [31:0] p_pc, p_instr, p_addr;
  logic        m_pend_v, mem_busy, p_adel, p_hold, p_reqhold;

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("init");

    // Directed cycle table; the first row is the IDLE cycle right after reset release.
    build_table();
    reset = 1'b0;
    foreach (tbl[i]) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("tbl%0d_ireq_valid", i), {31'b0, ireq_valid}, {31'b0, tbl[i].eiv});
      if (tbl[i].eiv) chk($sformatf("tbl%0d_ireq_addr", i), ireq_addr, tbl[i].ea);
      chk($sformatf("tbl%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].eov});
      if (tbl[i].eov) begin
        chk($sformatf("tbl%0d_out_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_out_pcplus4", i), out_pcplus4, tbl[i].epc + 32'd4);
        chk($sformatf("tbl%0d_out_instr", i), out_instr, tbl[i].ei);
        chk($sformatf("tbl%0d_out_adel", i), {31'b0, out_exc_adel}, {31'b0, tbl[i].ead});
      end
      drive(tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].rdir, tbl[i].rpc, tbl[i].fl, tbl[i].ep, tbl[i].st);
    end

    // Reset in the middle of an outstanding request, then a late response in IDLE.
    @(negedge clk);
    drive(1'b1, 1'b0, Z, 1'b0, Z, 1'b0, Z, 1'b0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    check_reset_outputs("midreq");
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'hFFFF0000, 1'b0, Z, 1'b0, Z, 1'b0);
    chk("late_idle_ireq_valid", {31'b0, ireq_valid}, 32'h0);
    @(negedge clk);
    chk("late_req_out_valid", {31'b0, out_valid}, 32'h0);
    chk("late_req_ireq_valid", {31'b0, ireq_valid}, 32'h1);
    chk("late_req_addr", ireq_addr, 32'hBFC00000);
    drive(1'b0, 1'b0, Z, 1'b0, Z, 1'b1, 32'hFFFFFFFC, 1'b0);

    // PC wrap at the top of the address space.
    @(negedge clk);
    chk("wrap_req_out_valid", {31'b0, out_valid}, 32'h0);
    chk("wrap_req_addr", ireq_addr, 32'hFFFFFFFC);
    drive(1'b1, 1'b0, Z, 1'b0, Z, 1'b0, Z, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0BADF00D, 1'b0, Z, 1'b0, Z, 1'b0);
    @(negedge clk);
    chk("wrap_out_valid", {31'b0, out_valid}, 32'h1);
    chk("wrap_out_pc", out_pc, 32'hFFFFFFFC);
    chk("wrap_out_pcplus4", out_pcplus4, 32'h00000000);
    chk("wrap_out_instr", out_instr, 32'h0BADF00D);
    idle_inputs();
    @(negedge clk);
    chk("wrap_next_ireq_valid", {31'b0, ireq_valid}, 32'h1);
    chk("wrap_next_addr", ireq_addr, 32'h00000000);

    // Random traffic against the stream model.
    apply_reset();
    m_pc = 32'hBFC00000; m_pend = '0; m_pend_v = 1'b0;
    mem_busy = 1'b0; mem_addr = '0;
    p_hold = 1'b0; p_reqhold = 1'b0;
    p_pc = '0; p_instr = '0; p_addr = '0; p_adel = 1'b0;
    begin
      int  idle_cnt;
      bit  acc, cons;
      logic [31:0] rpc;
      idle_cnt = 0;
      for (int c = 0; c < 4000; c++) begin
        if (c > 0) @(negedge clk);
        if (p_hold) begin
          chk("rnd_hold_valid", {31'b0, out_valid}, 32'h1);
          chk("rnd_hold_pc", out_pc, p_pc);
          chk("rnd_hold_instr", out_instr, p_instr);
          chk("rnd_hold_adel", {31'b0, out_exc_adel}, {31'b0, p_adel});
        end
        if (p_reqhold) begin
          chk("rnd_reqhold_valid", {31'b0, ireq_valid}, 32'h1);
          chk("rnd_reqhold_addr", ireq_addr, p_addr);
        end

        rpc = 32'h80000000 | ($urandom & 32'h0000FFFC);
        if ($urandom_range(0, 5) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
        drive($urandom_range(0, 3) != 0,
              mem_busy && ($urandom_range(0, 2) != 0),
              memf(mem_addr),
              $urandom_range(0, 11) == 0, rpc,
              $urandom_range(0, 39) == 0,
              ($urandom_range(0, 1) == 0) ? 32'hBFC00380 : (32'hBFC00000 | ($urandom & 32'h00000FFC)),
              $urandom_range(0, 3) == 0);

        acc  = ireq_valid && ireq_ready;
        cons = out_valid && !stall_f && !flush_f;
        if (acc) chk("rnd_req_addr", ireq_addr, m_pc);
        if (cons) begin
          chk("rnd_out_pc", out_pc, m_pc);
          chk("rnd_out_pcplus4", out_pcplus4, m_pc + 32'd4);
          chk("rnd_out_instr", out_instr, (m_pc[1:0] == 2'b00) ? memf(m_pc) : 32'h0);
          chk("rnd_out_adel", {31'b0, out_exc_adel}, {31'b0, m_pc[1:0] != 2'b00});
          idle_cnt = 0;
        end else begin
          idle_cnt++;
        end
        if (idle_cnt > 400) begin
          checks++;
          failures++;
          $display("FAIL rnd_progress no instruction delivered for %0d cycles, required progress", idle_cnt);
          break;
        end

        if (iresp_valid) mem_busy = 1'b0;
        if (acc) begin
          mem_busy = 1'b1;
          mem_addr = ireq_addr;
        end
        if (flush_f) begin
          m_pc = exc_pc;
          m_pend_v = 1'b0;
        end else if (cons) begin
          m_pc = redirect_valid ? redirect_pc : (m_pend_v ? m_pend : m_pc + 32'd4);
          m_pend_v = 1'b0;
        end else if (redirect_valid) begin
          m_pend = redirect_pc;
          m_pend_v = 1'b1;
        end

        p_hold    = out_valid && stall_f && !flush_f;
        p_reqhold = ireq_valid && !ireq_ready && !flush_f;
        p_pc = out_pc; p_instr = out_instr; p_adel = out_exc_adel; p_addr = ireq_addr;
      end
    end
    idle_inputs();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 ireq_valid  output  1  instruction fetch request valid.
REQ-004 ireq_addr  output  32  fetch address (PC).
REQ-005 ireq_ready  input  1  memory accepts request this cycle.
REQ-006 iresp_valid  input  1  instruction data returned this cycle.
REQ-007 iresp_data  input  32  returned instruction word.
REQ-008 redirect_valid  input  1  decode branch/jump/jr taken; one-cycle pulse.
REQ-009 redirect_pc  input  32  redirect target, already selected by decode.
REQ-010 flush_f  input  1  exception flush of fetch.
REQ-011 exc_pc  input  32  exception vector, valid with flush_f.
REQ-012 stall_f  input  1  downstream cannot accept fetched instruction.
REQ-013 out_valid  output  1  fetched instruction available to dreg.
REQ-014 out_pc  output  32  PC of fetched instruction.
REQ-015 out_pcplus4  output  32  out_pc + 4, modulo 2^32.
REQ-016 out_instr  output  32  fetched instruction word.
REQ-017 out_exc_adel  output  1  PC misaligned (address-error load on fetch).

Function
REQ-018 The block SHALL hold a PC register, a pending-target register with valid bit, a discard flag, and an instruction buffer.
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT, DONE; IDLE exists only after reset and moves to REQ the next cycle.
REQ-020 REQ: ireq_valid=1, ireq_addr=PC when PC[1:0]==0; on ireq_ready -> WAIT; ireq_addr SHALL stay stable until accepted.
REQ-021 REQ with PC[1:0]!=0: no request issued; buffer <= 0, adel <= 1; next state DONE.
REQ-022 WAIT: on iresp_valid with discard=0, buffer <= iresp_data, adel <= 0, -> DONE; with discard=1, drop the data, clear discard, -> REQ.
REQ-023 DONE: out_valid=1, outputs driven from PC/buffer; with stall_f=0, the instruction is consumed, PC <= next PC, -> REQ; with stall_f=1, all outputs held.
REQ-024 Next PC SHALL be the pending target if valid (pending valid then cleared), else PC+4.
REQ-025 redirect_valid SHALL be captured into the pending-target register in any state; the instruction currently in fetch (delay slot) SHALL complete normally.
REQ-026 redirect_valid in the same DONE cycle as consumption (stall_f=0) SHALL use redirect_pc directly as next PC.
REQ-027 flush_f SHALL override everything: PC <= exc_pc, pending target cleared, out_valid=0 from the next cycle.
REQ-028 flush_f in WAIT, or in REQ with ireq_ready=1 the same cycle: discard <= 1, -> WAIT (or stay in WAIT); the stale response is dropped, then REQ at exc_pc.
REQ-029 flush_f in REQ with ireq_ready=0, DONE, or IDLE: -> REQ at exc_pc next cycle.
REQ-030 flush_f and redirect_valid in the same cycle: the redirect SHALL be ignored.
REQ-031 At most one request SHALL be outstanding; ireq_valid=0 in WAIT, DONE, and IDLE.
REQ-032 out_pcplus4 SHALL wrap: 0xFFFFFFFC -> 0x00000000.

Reset
REQ-033 On reset: PC=0xBFC00000, state=IDLE, pending=0, discard=0, buffer=0, adel=0.
REQ-034 On reset: ireq_valid=0, out_valid=0, out_instr=0, out_exc_adel=0, out_pc=0xBFC00000.
REQ-035 Reset asserted mid-request SHALL abandon the request; any response arriving after reset deasserts SHALL be ignored while in IDLE.

Verification
REQ-036 Release reset, memory ready=1, one-cycle response 0x24020001 -> ireq_addr=0xBFC00000, then out_valid=1, out_instr=0x24020001, out_pcplus4=0xBFC00004.
REQ-037 Redirect pulse to 0x80001000 while fetching 0xBFC00004 -> delay slot 0xBFC00004 delivered, next request 0x80001000.
REQ-038 flush_f with exc_pc=0xBFC00380 while in WAIT for 0xBFC00008 -> response dropped, no out_valid for it, next ireq_addr=0xBFC00380.
REQ-039 redirect_pc=0x80000002 -> no request issued; out_valid=1, out_exc_adel=1, out_instr=0, out_pc=0x80000002.
REQ-040 stall_f=1 for 3 cycles in DONE plus ireq_ready=0 for 2 cycles in REQ -> outputs and ireq_addr held stable, no duplicate or skipped PC.
